// File: rtl/tpu_instr_fifo_if.sv
// Instruction types shared by the ingress FIFO and its host/consumer bus interface.
// The overflow signal exists only when TPU_INSTR_OVERFLOW_FLAG_EN is defined.
package tpu_instr_pkg;
   typedef logic [31:0] word_type;

   typedef struct packed {
      logic [23:0] buffer_addr;
      logic [15:0] acc_addr;
      logic [31:0] length;
      logic [7:0]  opcode;
   } instr_type;

   function automatic instr_type bit_to_instr(input logic [79:0] bits);
      return instr_type'(bits);
   endfunction
endpackage

interface tpu_instr_fifo_if #(parameter int FIFO_DEPTH = 32);
   import tpu_instr_pkg::*;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic           wr_en;
   logic [1:0]     wr_sel;
   word_type       wr_data;
   instr_type      instr;
   logic           instr_valid;
   logic           instr_ready;
   logic           full;
   logic           empty;
   logic [CW-1:0]  count;
`ifdef TPU_INSTR_OVERFLOW_FLAG_EN
   logic           overflow;

   modport master (output wr_en, wr_sel, wr_data, instr_ready,
                   input  instr, instr_valid, full, empty, count, overflow);
   modport slave  (input  wr_en, wr_sel, wr_data, instr_ready,
                   output instr, instr_valid, full, empty, count, overflow);
`else
   modport master (output wr_en, wr_sel, wr_data, instr_ready,
                   input  instr, instr_valid, full, empty, count);
   modport slave  (input  wr_en, wr_sel, wr_data, instr_ready,
                   output instr, instr_valid, full, empty, count);
`endif
endinterface

// File: rtl/tpu_instr_fifo.sv
// Assembles three host words into 80-bit instructions and queues them in a show-ahead FIFO.
// Optional sticky drop flag enabled by defining TPU_INSTR_OVERFLOW_FLAG_EN.
module tpu_instr_fifo
   import tpu_instr_pkg::*;
#(
   parameter int FIFO_DEPTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   tpu_instr_fifo_if.slave      bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [79:0]    mem [FIFO_DEPTH];

   logic [31:0]    low_q, low_d;
   logic [31:0]    mid_q, mid_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;

   logic           full_w, empty_w;
   logic           push_req, pop, push_ok;
   logic [79:0]    push_word;

   always_comb begin
      empty_w   = (count_q == '0);
      full_w    = (count_q == CW'(FIFO_DEPTH));
      push_req  = bus.wr_en && (bus.wr_sel == 2'd2);
      pop       = !empty_w && bus.instr_ready;
      // A full queue can still take a push when the head leaves in the same cycle.
      push_ok   = push_req && (!full_w || pop);
      push_word = {bus.wr_data[15:0], mid_q, low_q};

      low_d = low_q;
      mid_d = mid_q;
      if (bus.wr_en && bus.wr_sel == 2'd0) low_d = bus.wr_data;
      if (bus.wr_en && bus.wr_sel == 2'd1) mid_d = bus.wr_data;

      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         low_q    <= '0;
         mid_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         low_q    <= low_d;
         mid_q    <= mid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is never reset; stale slots are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= push_word;
   end

   assign bus.instr       = bit_to_instr(mem[rd_ptr_q]);
   assign bus.instr_valid = !empty_w;
   assign bus.full        = full_w;
   assign bus.empty       = empty_w;
   assign bus.count       = count_q;

`ifdef TPU_INSTR_OVERFLOW_FLAG_EN
   logic overflow_q, overflow_d;

   always_comb begin
      overflow_d = overflow_q | (push_req && !push_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) overflow_q <= 1'b0;
      else     overflow_q <= overflow_d;
   end

   assign bus.overflow = overflow_q;
`endif
endmodule

// File: tb/tb_tpu_instr_fifo.sv
// Directed plus randomized bench for tpu_instr_fifo against a queue-based reference model.
// Instance A uses FIFO_DEPTH=32, instance B uses FIFO_DEPTH=4 for the wrap-around run.
module tb_tpu_instr_fifo;
   import tpu_instr_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tpu_instr_fifo_if #(.FIFO_DEPTH(32)) ifa ();
   tpu_instr_fifo_if #(.FIFO_DEPTH(4))  ifb ();

   tpu_instr_fifo #(.FIFO_DEPTH(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   tpu_instr_fifo #(.FIFO_DEPTH(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   // Reference model: a queue of whole instructions plus the two holding words.
   logic [79:0] mq[$];
   logic [31:0] m_low, m_mid;
   bit          m_ovf;
   int          dep;
   bit          use_b;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          popped;
   logic [79:0] popped_obs;
   int          exp_op;
   int          npop;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      int          sz;
      logic [79:0] oi;
      logic [31:0] oc;
      logic        ov, oe, of;
      sz = mq.size();
      if (use_b) begin
         oi = ifb.instr; oc = 32'(ifb.count); ov = ifb.instr_valid; oe = ifb.empty; of = ifb.full;
      end else begin
         oi = ifa.instr; oc = 32'(ifa.count); ov = ifa.instr_valid; oe = ifa.empty; of = ifa.full;
      end
      chk("count", 80'(oc), 80'(sz));
      chk("empty", 80'(oe), 80'(sz == 0));
      chk("full",  80'(of), 80'(sz == dep));
      chk("instr_valid", 80'(ov), 80'(sz != 0));
      if (sz != 0) chk("instr", oi, mq[0]);
`ifdef TPU_INSTR_OVERFLOW_FLAG_EN
      if (!use_b) chk("overflow", 80'(ifa.overflow), 80'(m_ovf));
`endif
   endtask

   // Drive one cycle of inputs, advance the model by the same edge, then compare.
   task automatic step(input logic en, input logic [1:0] sel, input logic [31:0] data, input logic rdy);
      bit          do_pop, acc;
      logic [79:0] ni;
      if (use_b) begin
         ifb.wr_en = en; ifb.wr_sel = sel; ifb.wr_data = data; ifb.instr_ready = rdy;
         ifa.wr_en = 1'b0; ifa.instr_ready = 1'b0;
      end else begin
         ifa.wr_en = en; ifa.wr_sel = sel; ifa.wr_data = data; ifa.instr_ready = rdy;
         ifb.wr_en = 1'b0; ifb.instr_ready = 1'b0;
      end
      do_pop = rdy && (mq.size() != 0) && !rst;
      popped = do_pop;
      if (do_pop) popped_obs = use_b ? ifb.instr : ifa.instr;
      acc = en && (sel == 2'd2) && ((mq.size() < dep) || do_pop);
      ni  = {data[15:0], m_mid, m_low};
      @(posedge clk);
      #1;
      if (rst) begin
         mq.delete();
         m_low = '0; m_mid = '0; m_ovf = 1'b0;
      end else begin
         if (en && sel == 2'd2 && !acc) m_ovf = 1'b1;
         if (do_pop) void'(mq.pop_front());
         if (acc) mq.push_back(ni);
         if (en && sel == 2'd0) m_low = data;
         if (en && sel == 2'd1) m_mid = data;
      end
      check_state();
   endtask

   task automatic step_w(input logic en, input logic [1:0] sel, input logic [31:0] data, input logic rdy);
      step(en, sel, data, rdy);
      if (popped) begin
         chk("wrap_order", 80'(popped_obs[7:0]), 80'(exp_op[7:0]));
         exp_op++;
         npop++;
      end
   endtask

   initial begin
      instr_type   t;
      logic [79:0] held, w;
      logic        r;

      rst = 1'b1;
      ifa.wr_en = 1'b0; ifa.wr_sel = 2'd0; ifa.wr_data = '0; ifa.instr_ready = 1'b0;
      ifb.wr_en = 1'b0; ifb.wr_sel = 2'd0; ifb.wr_data = '0; ifb.instr_ready = 1'b0;
      use_b = 1'b0; dep = 32; m_low = '0; m_mid = '0; m_ovf = 1'b0;

      step(1'b0, 2'd0, 32'h0, 1'b0);
      rst = 1'b0;

      // Single instruction; mid's top byte 0x40 lands in buffer_addr[7:0], acc_addr gets mid[23:8].
      step(1'b1, 2'd0, 32'h0000_0301, 1'b0);
      step(1'b1, 2'd1, 32'h4000_0000, 1'b0);
      step(1'b1, 2'd2, 32'h0000_ABCD, 1'b0);
      t = ifa.instr;
      chk("single_opcode", 80'(t.opcode), 80'(8'h01));
      chk("single_length", 80'(t.length), 80'(32'h0000_0003));
      chk("single_acc",    80'(t.acc_addr), 80'(16'h0000));
      chk("single_buf",    80'(t.buffer_addr), 80'(24'hABCD40));

      // Fill, simultaneous push/pop at full, then a dropped push.
      rst = 1'b1; step(1'b0, 2'd0, 32'h0, 1'b0); rst = 1'b0;
      step(1'b1, 2'd0, $urandom, 1'b0);
      step(1'b1, 2'd1, $urandom, 1'b0);
      for (int i = 0; i < 32; i++) step(1'b1, 2'd2, $urandom, 1'b0);
      chk("fill_full", 80'(ifa.full), 80'(1));
      step(1'b1, 2'd2, $urandom, 1'b1);
      chk("simul_count", 80'(ifa.count), 80'(32));
      step(1'b1, 2'd2, $urandom, 1'b0);
      for (int k = 0; k < 400 && mq.size() != 0; k++) step(1'b0, 2'd0, 32'h0, 1'($urandom));
      chk("drain_empty", 80'(ifa.empty), 80'(1));

      // Backpressure stall, then re-issue by rewriting only the top word.
      step(1'b1, 2'd0, 32'h1122_3344, 1'b0);
      step(1'b1, 2'd1, 32'h00AB_CDEF, 1'b0);
      step(1'b1, 2'd2, 32'hFFFF_5678, 1'b0);
      held = ifa.instr;
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 2'd0, 32'h0, 1'b0);
         chk("stall_stable", ifa.instr, held);
      end
      step(1'b1, 2'd2, 32'h0000_1234, 1'b0);
      step(1'b0, 2'd0, 32'h0, 1'b1);
      t = ifa.instr;
      w = ifa.instr;
      chk("reissue_buf",   80'(t.buffer_addr), 80'(24'h123400));
      chk("reissue_low64", 80'(w[63:0]), 80'(held[63:0]));

      // Reset with five entries queued; ready high during reset is ignored.
      for (int i = 0; i < 4; i++) step(1'b1, 2'd2, $urandom, 1'b0);
      chk("pre_rst_count", 80'(ifa.count), 80'(5));
      rst = 1'b1; step(1'b0, 2'd0, 32'h0, 1'b1); rst = 1'b0;
      step(1'b1, 2'd2, 32'h0000_BEEF, 1'b0);
      w = ifa.instr;
      chk("post_rst_low64", 80'(w[63:0]), 80'(0));

      // Wrap-around on the depth-4 instance with random backpressure.
      use_b = 1'b1; dep = 4;
      mq.delete(); m_low = '0; m_mid = '0; m_ovf = 1'b0;
      exp_op = 0; npop = 0;
      for (int i = 0; i < 100; i++) begin
         step_w(1'b1, 2'd0, ($urandom & 32'hFFFF_FF00) | 32'(i), 1'($urandom));
         step_w(1'b1, 2'd1, $urandom, 1'($urandom));
         r = (mq.size() == dep) ? 1'b1 : 1'($urandom);
         step_w(1'b1, 2'd2, $urandom, r);
      end
      for (int k = 0; k < 20 && mq.size() != 0; k++) step_w(1'b0, 2'd0, 32'h0, 1'b1);
      chk("wrap_total", 80'(npop), 80'(100));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
